texel_serializer: RTL and testbench

// - Transmit side of the 32-bit triangle word stream that the texel assembler receives.
// - Takes one 168-bit triangle (three vertices plus colour) at a time from an upstream producer.
// - Emits it as one FRAME_START word followed by 6 data words into an AHB write buffer.
// - Emits one FRAME_END word on request at end of frame. Used on the host/loopback path.

---
 rtl/texel_pkg.sv | 24 ++
 rtl/texel_serializer.sv | 124 ++++++++++++
 tb/tb_texel_serializer.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/texel_pkg.sv
// ============================================================================
// Module  : texel_pkg
// Brief   : Constants and state encoding shared by texel serializer/assembler.
// Revision: 1.0
// ============================================================================
`default_nettype none

package texel_pkg;

  localparam logic [31:0] FRAME_START = 32'd0;
  localparam logic [31:0] FRAME_END   = 32'd1;
  localparam int          TEXEL_W     = 168;
  localparam int          NUM_WORDS   = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_DATA    = 2'd2,
    ST_TRAILER = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/texel_serializer.sv
// ============================================================================
// Module  : texel_serializer
// Brief   : Sends each 168-bit triangle as FRAME_START + 6 words, FRAME_END on request.
// Revision: 1.0
// ============================================================================
`default_nettype none

module texel_serializer
  import texel_pkg::*;
(
  input  logic               clk,
  input  logic               n_rst,
  input  logic [TEXEL_W-1:0] texel_buffer,
  input  logic               texel_ready,
  output logic               texel_read,
  input  logic               frame_done,
  input  logic               ahb_write_ready,
  output logic [31:0]        ahb_write_data,
  output logic               ahb_write_valid,
  output logic               busy
);

  localparam logic [2:0] c_LAST_WORD = 3'(NUM_WORDS - 1);

  state_t               r_state;
  logic [2:0]           r_word_cnt;
  logic                 r_end_pending;
  logic [TEXEL_W-1:0]   r_shadow;

  state_t               w_next_state;
  logic [2:0]           w_next_cnt;
  logic                 w_next_pend;
  logic                 w_capture;
  logic                 w_valid;
  logic [31:0]          w_data;
  logic [31:0]          w_word;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state       <= ST_IDLE;
      r_word_cnt    <= 3'd0;
      r_end_pending <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_word_cnt    <= w_next_cnt;
      r_end_pending <= w_next_pend;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_shadow <= '0;
    end else if (w_capture) begin
      r_shadow <= texel_buffer;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_word_cnt;
    // A new request always wins; the TRAILER transfer only clears a stale one.
    w_next_pend  = r_end_pending | frame_done;
    w_capture    = 1'b0;
    w_valid      = 1'b0;
    w_data       = 32'd0;

    case (r_word_cnt)
      3'd0:    w_word = r_shadow[31:0];
      3'd1:    w_word = r_shadow[63:32];
      3'd2:    w_word = r_shadow[95:64];
      3'd3:    w_word = r_shadow[127:96];
      3'd4:    w_word = r_shadow[159:128];
      3'd5:    w_word = {24'd0, r_shadow[167:160]};
      default: w_word = 32'd0;
    endcase

    case (r_state)
      ST_IDLE: begin
        if (texel_ready) begin
          w_capture    = n_rst;
          w_next_state = ST_HDR;
        end else if (r_end_pending) begin
          w_next_state = ST_TRAILER;
        end
      end
      ST_HDR: begin
        w_valid = 1'b1;
        w_data  = FRAME_START;
        if (ahb_write_ready) begin
          w_next_cnt   = 3'd0;
          w_next_state = ST_DATA;
        end
      end
      ST_DATA: begin
        w_valid = 1'b1;
        w_data  = w_word;
        if (ahb_write_ready) begin
          if (r_word_cnt == c_LAST_WORD) begin
            w_next_state = ST_IDLE;
          end else begin
            w_next_cnt = r_word_cnt + 3'd1;
          end
        end
      end
      ST_TRAILER: begin
        w_valid = 1'b1;
        w_data  = FRAME_END;
        if (ahb_write_ready) begin
          w_next_state = ST_IDLE;
          w_next_pend  = frame_done;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign texel_read      = w_capture;
  assign ahb_write_valid = w_valid;
  assign ahb_write_data  = w_data;
  assign busy            = (r_state != ST_IDLE) || r_end_pending;

endmodule

`default_nettype wire

// File: tb/tb_texel_serializer.sv
// ============================================================================
// Module  : tb_texel_serializer
// Brief   : Directed self-checking bench for texel_serializer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_texel_serializer;
  import texel_pkg::*;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic [167:0] texel_buffer = '0;
  logic         texel_ready = 1'b0;
  logic         frame_done = 1'b0;
  logic         ahb_write_ready = 1'b1;
  logic         texel_read;
  logic [31:0]  ahb_write_data;
  logic         ahb_write_valid;
  logic         busy;

  int total = 0;
  int passed = 0;
  int cyc = 0;
  int stall_err = 0;

  logic [31:0] q[$];
  logic [31:0] exp_q[$];
  int          rd_cyc[$];
  logic        pv;
  logic        pr;
  logic [31:0] pd;

  localparam logic [167:0] T_SINGLE = {8'hA5, 32'h55555555, 32'h44444444,
                                       32'h33333333, 32'h22222222, 32'h11111111};
  localparam logic [167:0] T_TWO = {8'h3C, 32'hDEADBEEF, 32'hCAFEF00D,
                                    32'h01234567, 32'h89ABCDEF, 32'h0F0F0F0F};

  texel_serializer dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .texel_buffer    (texel_buffer),
    .texel_ready     (texel_ready),
    .texel_read      (texel_read),
    .frame_done      (frame_done),
    .ahb_write_ready (ahb_write_ready),
    .ahb_write_data  (ahb_write_data),
    .ahb_write_valid (ahb_write_valid),
    .busy            (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Word collector and stall-stability watcher, sampled on the falling edge.
  always @(negedge clk) begin
    if (!n_rst) begin
      pv <= 1'b0;
    end else begin
      if (ahb_write_valid && ahb_write_ready) q.push_back(ahb_write_data);
      if (texel_read) rd_cyc.push_back(cyc);
      if (pv && !pr && (!ahb_write_valid || ahb_write_data !== pd)) stall_err <= stall_err + 1;
      pv <= ahb_write_valid;
      pr <= ahb_write_ready;
      pd <= ahb_write_data;
    end
  end

  function automatic void push_pkt(input logic [167:0] t);
    exp_q.push_back(FRAME_START);
    for (int i = 0; i < 5; i++) exp_q.push_back(t[32*i +: 32]);
    exp_q.push_back({24'd0, t[167:160]});
  endfunction

  task automatic send(input logic [167:0] t);
    bit got = 0;
    @(posedge clk); #1;
    texel_buffer = t;
    texel_ready  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (texel_read) begin got = 1; break; end
    end
    @(posedge clk); #1;
    texel_ready = 1'b0;
    total++;
    if (!got) $display("FAIL send_capture texel_read got 0 want 1");
    else passed++;
  endtask

  task automatic drain(input bit rnd);
    bit done = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (rnd) ahb_write_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (!busy) begin done = 1; break; end
    end
    ahb_write_ready = 1'b1;
    total++;
    if (!done) $display("FAIL drain_timeout busy got 1 want 0");
    else passed++;
  endtask

  task automatic compare_words(input string name);
    total++;
    if (q.size() != exp_q.size())
      $display("FAIL %s_len words got %0d want %0d", name, q.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < q.size() && i < exp_q.size(); i++) begin
      total++;
      if (q[i] !== exp_q[i])
        $display("FAIL %s_word%0d got %08h want %08h", name, i, q[i], exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({ahb_write_valid, busy, texel_read, ahb_write_data} !== 35'd0)
      $display("FAIL reset_outputs got %09h want 0",
               {ahb_write_valid, busy, texel_read, ahb_write_data});
    else passed++;
    @(posedge clk); #1;
    n_rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if ({ahb_write_valid, busy, texel_read, ahb_write_data} !== 35'd0)
        $display("FAIL idle_quiet cycle %0d got %09h want 0", i,
                 {ahb_write_valid, busy, texel_read, ahb_write_data});
      else passed++;
    end
  endtask

  task automatic test_single();
    q.delete(); exp_q.delete(); rd_cyc.delete();
    push_pkt(T_SINGLE);
    send(T_SINGLE);
    drain(0);
    compare_words("single");
    total++;
    if (rd_cyc.size() != 1) $display("FAIL single_read_pulses got %0d want 1", rd_cyc.size());
    else passed++;
    total++;
    if (rd_cyc.size() > 0 && cyc - rd_cyc[0] != 8)
      $display("FAIL single_idle_cycle got %0d want 8", cyc - rd_cyc[0]);
    else passed++;
  endtask

  task automatic test_backpressure();
    bit seen = 0;
    q.delete(); exp_q.delete(); stall_err = 0;
    push_pkt(T_SINGLE);
    send(T_SINGLE);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ahb_write_valid && ahb_write_data == 32'h11111111) begin seen = 1; break; end
    end
    @(posedge clk); #1;
    ahb_write_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (!seen || ahb_write_valid !== 1'b1 || ahb_write_data !== 32'h22222222)
        $display("FAIL stall_hold cycle %0d got %08h want 22222222", i, ahb_write_data);
      else passed++;
    end
    @(posedge clk); #1;
    ahb_write_ready = 1'b1;
    drain(0);
    compare_words("stall");
    send(T_TWO);
    push_pkt(T_TWO);
    drain(1);
    compare_words("random_bp");
    total++;
    if (stall_err != 0) $display("FAIL stall_stable violations got %0d want 0", stall_err);
    else passed++;
  endtask

  task automatic test_back_to_back();
    bit got = 0;
    q.delete(); exp_q.delete(); rd_cyc.delete();
    push_pkt(T_SINGLE);
    push_pkt(T_TWO);
    @(posedge clk); #1;
    texel_buffer = T_SINGLE;
    texel_ready  = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = texel_read; end
    @(posedge clk); #1;
    texel_buffer = T_TWO;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = texel_read; end
    @(posedge clk); #1;
    texel_ready = 1'b0;
    drain(0);
    compare_words("b2b");
    total++;
    if (rd_cyc.size() != 2 || rd_cyc[1] - rd_cyc[0] != 8)
      $display("FAIL b2b_read_spacing got %0d reads want 2 reads 8 apart", rd_cyc.size());
    else passed++;
  endtask

  task automatic test_frame_end();
    bit seen = 0;
    // frame_done during DATA word 3
    q.delete(); exp_q.delete();
    push_pkt(T_SINGLE); exp_q.push_back(FRAME_END);
    send(T_SINGLE);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk); seen = ahb_write_valid && ahb_write_data == 32'h33333333;
    end
    frame_done = 1'b1;
    @(posedge clk); #1; frame_done = 1'b0;
    drain(0);
    compare_words("fe_word3");
    // two pulses absorbed into one trailer
    q.delete(); exp_q.delete();
    push_pkt(T_TWO); exp_q.push_back(FRAME_END);
    send(T_TWO);
    frame_done = 1'b1; @(posedge clk); #1; frame_done = 1'b0;
    @(posedge clk); #1; frame_done = 1'b1; @(posedge clk); #1; frame_done = 1'b0;
    drain(0);
    compare_words("fe_double");
    // frame_done and texel_ready together in IDLE: triangle first
    q.delete(); exp_q.delete();
    push_pkt(T_SINGLE); exp_q.push_back(FRAME_END);
    @(posedge clk); #1;
    texel_buffer = T_SINGLE; texel_ready = 1'b1; frame_done = 1'b1;
    @(posedge clk); #1;
    texel_ready = 1'b0; frame_done = 1'b0;
    drain(0);
    compare_words("fe_idle_prio");
    // frame_done coincident with the TRAILER transfer yields a second trailer
    q.delete(); exp_q.delete();
    exp_q.push_back(FRAME_END); exp_q.push_back(FRAME_END);
    @(posedge clk); #1; frame_done = 1'b1; @(posedge clk); #1; frame_done = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk); seen = ahb_write_valid && ahb_write_data == FRAME_END;
    end
    frame_done = 1'b1;
    @(posedge clk); #1; frame_done = 1'b0;
    drain(0);
    compare_words("fe_retrigger");
  endtask

  task automatic test_loopback();
    logic [167:0] t;
    q.delete(); exp_q.delete(); stall_err = 0;
    for (int n = 0; n < 20; n++) begin
      for (int w = 0; w < 6; w++) t[32*w +: 32] = 32'($urandom);
      push_pkt(t);
      send(t);
      drain(1);
    end
    compare_words("loopback");
    total++;
    if (stall_err != 0) $display("FAIL loop_stable violations got %0d want 0", stall_err);
    else passed++;
  endtask

  task automatic test_reset_mid_data();
    bit seen = 0;
    send(T_SINGLE);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk); seen = ahb_write_valid && ahb_write_data == 32'h33333333;
    end
    frame_done = 1'b1;
    @(posedge clk); #1;
    frame_done  = 1'b0;
    texel_ready = 1'b1;
    n_rst       = 1'b0;
    #1;
    total++;
    if ({ahb_write_valid, busy, texel_read, ahb_write_data} !== 35'd0)
      $display("FAIL rst_mid_data got %09h want 0",
               {ahb_write_valid, busy, texel_read, ahb_write_data});
    else passed++;
    texel_ready = 1'b0;
    @(posedge clk); #1;
    n_rst = 1'b1;
    q.delete();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (ahb_write_valid !== 1'b0 || busy !== 1'b0)
        $display("FAIL rst_no_resume cycle %0d got valid=%0b busy=%0b want 0 0",
                 i, ahb_write_valid, busy);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_frame_end();
    test_loopback();
    test_reset_mid_data();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
